// File: rtl/mem_access_stage.sv
// ============================================================================
//  Module   : mem_access_stage
//  Purpose  : RV32 pipeline memory stage. It issues loads and stores over a
//             req/gnt/rvalid data-memory port, and formats load data
//             (lane select plus sign/zero extension). It registers the
//             instruction payload toward writeback.
//  Options  : MEM_MISALIGN_TRAP_EN - when defined, misaligned halfword/word
//             accesses skip memory and retire with wb_misalign_o = 1.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CONTROL_BIT
`define CONTROL_BIT 8
`endif
`ifndef I_NOP
`define I_NOP 32'h0000_0013
`endif
`ifndef CONTROL_NOP
`define CONTROL_NOP {`CONTROL_BIT{1'b0}}
`endif

module mem_access_stage (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [31:0]             exec_instr_i,
  input  logic [`CONTROL_BIT-1:0] exec_control_i,
  input  logic [31:0]             exec_alu_result_i,
  input  logic [31:0]             exec_data_i,
  input  logic [4:0]              exec_rd_addr_i,
  input  logic [31:0]             exec_pcplus_i,
  output logic                    exec_ready_o,
  output logic                    dmem_req_o,
  output logic                    dmem_we_o,
  output logic [31:0]             dmem_addr_o,
  output logic [31:0]             dmem_wdata_o,
  output logic [3:0]              dmem_be_o,
  input  logic                    dmem_gnt_i,
  input  logic                    dmem_rvalid_i,
  input  logic [31:0]             dmem_rdata_i,
  output logic [31:0]             wb_instr_o,
  output logic [`CONTROL_BIT-1:0] wb_control_o,
  output logic [31:0]             wb_alu_result_o,
  output logic [4:0]              wb_rd_addr_o,
  output logic [31:0]             wb_pcplus_o,
  output logic [31:0]             wb_load_data_o,
  output logic                    wb_misalign_o,
  input  logic                    wb_ready_i
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_REQ  = 2'd1;
  localparam logic [1:0] c_RSP  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] c_OP_STORE = 7'b0100011;

  logic [1:0]              r_state;
  logic [1:0]              w_next_state;

  logic [6:0]              w_opcode;
  logic [2:0]              w_funct3;
  logic                    w_is_load;
  logic                    w_is_store;
  logic                    w_is_mem;
  logic                    w_misalign;
  logic                    w_cap_exec;
  logic                    w_cap_done;

  logic [3:0]              w_be;
  logic [31:0]             w_wdata;
  logic [7:0]              w_lane_b;
  logic [15:0]             w_lane_h;
  logic [31:0]             w_ld_fmt;

  // Payload of the memory op currently in flight
  logic [31:0]             r_op_instr;
  logic [`CONTROL_BIT-1:0] r_op_control;
  logic [31:0]             r_op_alu;
  logic [4:0]              r_op_rd;
  logic [31:0]             r_op_pcplus;
  logic [31:0]             r_buf;

  logic                    r_dmem_req;
  logic                    r_dmem_we;
  logic [31:0]             r_dmem_addr;
  logic [31:0]             r_dmem_wdata;
  logic [3:0]              r_dmem_be;

  logic [31:0]             r_wb_instr;
  logic [`CONTROL_BIT-1:0] r_wb_control;
  logic [31:0]             r_wb_alu;
  logic [4:0]              r_wb_rd;
  logic [31:0]             r_wb_pcplus;
  logic [31:0]             r_wb_ld;

  assign w_opcode   = exec_instr_i[6:0];
  assign w_funct3   = exec_instr_i[14:12];
  assign w_is_load  = (w_opcode == c_OP_LOAD) &&
                      ((w_funct3 == 3'b000) || (w_funct3 == 3'b001) ||
                       (w_funct3 == 3'b010) || (w_funct3 == 3'b100) ||
                       (w_funct3 == 3'b101));
  assign w_is_store = (w_opcode == c_OP_STORE) &&
                      ((w_funct3 == 3'b000) || (w_funct3 == 3'b001) ||
                       (w_funct3 == 3'b010));
  assign w_is_mem   = w_is_load | w_is_store;

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = w_is_mem &&
                      (((w_funct3[1:0] == 2'b01) && exec_alu_result_i[0]) ||
                       ((w_funct3[1:0] == 2'b10) && (exec_alu_result_i[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  // Writeback captures: a non-memory op straight from IDLE, or a finished access
  assign w_cap_exec = (r_state == c_IDLE) && !w_is_mem && wb_ready_i;
  assign w_cap_done = (r_state == c_DONE) && wb_ready_i;

  // Byte enables and lane-replicated store data from size and address
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = exec_data_i;
    case (w_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << exec_alu_result_i[1:0];
        w_wdata = {4{exec_data_i[7:0]}};
      end
      2'b01: begin
        w_be    = exec_alu_result_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{exec_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load alignment: pick the lane, then sign- or zero-extend per funct3
  always_comb begin
    case (r_op_alu[1:0])
      2'b01:   w_lane_b = dmem_rdata_i[15:8];
      2'b10:   w_lane_b = dmem_rdata_i[23:16];
      2'b11:   w_lane_b = dmem_rdata_i[31:24];
      default: w_lane_b = dmem_rdata_i[7:0];
    endcase
    w_lane_h = r_op_alu[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (r_op_instr[14:12])
      3'b000:  w_ld_fmt = {{24{w_lane_b[7]}}, w_lane_b};
      3'b100:  w_ld_fmt = {24'h0, w_lane_b};
      3'b001:  w_ld_fmt = {{16{w_lane_h[15]}}, w_lane_h};
      3'b101:  w_ld_fmt = {16'h0, w_lane_h};
      default: w_ld_fmt = dmem_rdata_i;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= c_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next-state logic; rvalid only matters in RSP
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: if (w_is_mem)      w_next_state = w_misalign ? c_DONE : c_REQ;
      c_REQ:  if (dmem_gnt_i)    w_next_state = r_dmem_we ? c_DONE : c_RSP;
      c_RSP:  if (dmem_rvalid_i) w_next_state = c_DONE;
      c_DONE: if (wb_ready_i)    w_next_state = c_IDLE;
      default:                   w_next_state = c_IDLE;
    endcase
  end

  // FSM outputs: execute may advance only when this cycle retires something
  always_comb begin
    exec_ready_o = 1'b0;
    case (r_state)
      c_IDLE:  exec_ready_o = !w_is_mem && wb_ready_i;
      c_DONE:  exec_ready_o = wb_ready_i;
      default: exec_ready_o = 1'b0;
    endcase
  end

  // Memory-op capture, dmem request registers and load buffer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op_instr   <= `I_NOP;
      r_op_control <= `CONTROL_NOP;
      r_op_alu     <= 32'h0;
      r_op_rd      <= 5'h0;
      r_op_pcplus  <= 32'h0;
      r_buf        <= 32'h0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= 32'h0;
      r_dmem_wdata <= 32'h0;
      r_dmem_be    <= 4'h0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_is_mem) begin
            r_op_instr   <= exec_instr_i;
            r_op_control <= exec_control_i;
            r_op_alu     <= exec_alu_result_i;
            r_op_rd      <= exec_rd_addr_i;
            r_op_pcplus  <= exec_pcplus_i;
            r_buf        <= 32'h0;
            r_dmem_req   <= !w_misalign;
            r_dmem_we    <= w_is_store;
            r_dmem_addr  <= {exec_alu_result_i[31:2], 2'b00};
            r_dmem_wdata <= w_wdata;
            r_dmem_be    <= w_misalign ? 4'h0 : w_be;
          end
        end
        c_REQ: begin
          if (dmem_gnt_i) r_dmem_req <= 1'b0;
        end
        c_RSP: begin
          if (dmem_rvalid_i) r_buf <= w_ld_fmt;
        end
        default: ;
      endcase
    end
  end

  // Writeback payload registers; held whenever writeback stalls
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wb_instr   <= `I_NOP;
      r_wb_control <= `CONTROL_NOP;
      r_wb_alu     <= 32'h0;
      r_wb_rd      <= 5'h0;
      r_wb_pcplus  <= 32'h0;
      r_wb_ld      <= 32'h0;
    end else if (w_cap_exec) begin
      r_wb_instr   <= exec_instr_i;
      r_wb_control <= exec_control_i;
      r_wb_alu     <= exec_alu_result_i;
      r_wb_rd      <= exec_rd_addr_i;
      r_wb_pcplus  <= exec_pcplus_i;
      r_wb_ld      <= 32'h0;
    end else if (w_cap_done) begin
      r_wb_instr   <= r_op_instr;
      r_wb_control <= r_op_control;
      r_wb_alu     <= r_op_alu;
      r_wb_rd      <= r_op_rd;
      r_wb_pcplus  <= r_op_pcplus;
      r_wb_ld      <= r_buf;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_op_misalign;
  logic r_wb_misalign;

  // Misalign flag follows its op from IDLE through to writeback
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op_misalign <= 1'b0;
      r_wb_misalign <= 1'b0;
    end else begin
      if ((r_state == c_IDLE) && w_is_mem) r_op_misalign <= w_misalign;
      if (w_cap_exec)      r_wb_misalign <= 1'b0;
      else if (w_cap_done) r_wb_misalign <= r_op_misalign;
    end
  end

  assign wb_misalign_o = r_wb_misalign;
`else
  assign wb_misalign_o = 1'b0;
`endif

  assign dmem_req_o      = r_dmem_req;
  assign dmem_we_o       = r_dmem_we;
  assign dmem_addr_o     = r_dmem_addr;
  assign dmem_wdata_o    = r_dmem_wdata;
  assign dmem_be_o       = r_dmem_be;

  assign wb_instr_o      = r_wb_instr;
  assign wb_control_o    = r_wb_control;
  assign wb_alu_result_o = r_wb_alu;
  assign wb_rd_addr_o    = r_wb_rd;
  assign wb_pcplus_o     = r_wb_pcplus;
  assign wb_load_data_o  = r_wb_ld;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
//  Module   : tb_mem_access_stage
//  Purpose  : Directed bench for mem_access_stage. It includes a small data
//             memory responder, and a scoreboard of expected writeback
//             payloads.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

`ifndef CONTROL_BIT
`define CONTROL_BIT 8
`endif
`ifndef I_NOP
`define I_NOP 32'h0000_0013
`endif
`ifndef CONTROL_NOP
`define CONTROL_NOP {`CONTROL_BIT{1'b0}}
`endif

module tb_mem_access_stage;

  logic                    clk = 1'b0;
  logic                    rst_i;
  logic [31:0]             exec_instr_i;
  logic [`CONTROL_BIT-1:0] exec_control_i;
  logic [31:0]             exec_alu_result_i;
  logic [31:0]             exec_data_i;
  logic [4:0]              exec_rd_addr_i;
  logic [31:0]             exec_pcplus_i;
  logic                    exec_ready_o;
  logic                    dmem_req_o;
  logic                    dmem_we_o;
  logic [31:0]             dmem_addr_o;
  logic [31:0]             dmem_wdata_o;
  logic [3:0]              dmem_be_o;
  logic                    dmem_gnt_i;
  logic                    dmem_rvalid_i;
  logic [31:0]             dmem_rdata_i;
  logic [31:0]             wb_instr_o;
  logic [`CONTROL_BIT-1:0] wb_control_o;
  logic [31:0]             wb_alu_result_o;
  logic [4:0]              wb_rd_addr_o;
  logic [31:0]             wb_pcplus_o;
  logic [31:0]             wb_load_data_o;
  logic                    wb_misalign_o;
  logic                    wb_ready_i;

  mem_access_stage u_dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .exec_instr_i      (exec_instr_i),
    .exec_control_i    (exec_control_i),
    .exec_alu_result_i (exec_alu_result_i),
    .exec_data_i       (exec_data_i),
    .exec_rd_addr_i    (exec_rd_addr_i),
    .exec_pcplus_i     (exec_pcplus_i),
    .exec_ready_o      (exec_ready_o),
    .dmem_req_o        (dmem_req_o),
    .dmem_we_o         (dmem_we_o),
    .dmem_addr_o       (dmem_addr_o),
    .dmem_wdata_o      (dmem_wdata_o),
    .dmem_be_o         (dmem_be_o),
    .dmem_gnt_i        (dmem_gnt_i),
    .dmem_rvalid_i     (dmem_rvalid_i),
    .dmem_rdata_i      (dmem_rdata_i),
    .wb_instr_o        (wb_instr_o),
    .wb_control_o      (wb_control_o),
    .wb_alu_result_o   (wb_alu_result_o),
    .wb_rd_addr_o      (wb_rd_addr_o),
    .wb_pcplus_o       (wb_pcplus_o),
    .wb_load_data_o    (wb_load_data_o),
    .wb_misalign_o     (wb_misalign_o),
    .wb_ready_i        (wb_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]             instr;
    logic [`CONTROL_BIT-1:0] ctrl;
    logic [31:0]             alu;
    logic [4:0]              rd;
    logic [31:0]             pc;
    logic [31:0]             ld;
    logic                    mis;
  } exp_t;

  exp_t        sb[$];
  exp_t        last;
  logic [31:0] mem [0:255];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          pend  = 1'b0;
  logic [31:0] op_id = 32'h0;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_ALUI  = 7'b0010011;

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd);
    return {17'h0, f3, rd, opc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive_nop();
    exec_instr_i      = `I_NOP;
    exec_control_i    = `CONTROL_NOP;
    exec_alu_result_i = 32'h0;
    exec_data_i       = 32'h0;
    exec_rd_addr_i    = 5'h0;
    exec_pcplus_i     = 32'h0;
  endtask

  // Compare the writeback registers with the oldest scoreboard entry
  task automatic check_wb();
    exp_t e;
    pend = 1'b0;
    chk("sb_nonempty", {31'h0, sb.size() != 0}, 32'h1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("wb_instr",  wb_instr_o, e.instr);
    chk("wb_ctrl",   {{(32-`CONTROL_BIT){1'b0}}, wb_control_o}, {{(32-`CONTROL_BIT){1'b0}}, e.ctrl});
    chk("wb_alu",    wb_alu_result_o, e.alu);
    chk("wb_rd",     {27'h0, wb_rd_addr_o}, {27'h0, e.rd});
    chk("wb_pc",     wb_pcplus_o, e.pc);
    chk("wb_ld",     wb_load_data_o, e.ld);
    chk("wb_mis",    {31'h0, wb_misalign_o}, {31'h0, e.mis});
    last = e;
  endtask

  // Present one op, act as memory with the given delays, and wait for retirement
  task automatic run_op(input logic [31:0] instr, input logic [4:0] rd, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_ld, input logic exp_mis,
                        input int exp_req, input logic exp_we, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input int gnt_dly, input int rv_dly,
                        input bit rv_with_gnt, input int stall, input int exp_lat);
    logic [`CONTROL_BIT-1:0] ctrl;
    logic [31:0] pc;
    logic [31:0] req_addr;
    int req_cnt, req_cycles, rsp_wait, stall_left, lat;
    bit prev_req, granted, answered, done_phase, fin;
    op_id = op_id + 32'h1;
    for (int i = 0; i < `CONTROL_BIT; i++) ctrl[i] = op_id[i % 8] ^ i[0];
    pc = 32'h1000 + (op_id << 2);
    sb.push_back('{instr, ctrl, addr, rd, pc, exp_ld, exp_mis});
    req_cnt = 0; req_cycles = 0; rsp_wait = 0; stall_left = stall; lat = -1;
    prev_req = 1'b0; granted = 1'b0; answered = 1'b0; done_phase = (exp_req == 0);
    req_addr = 32'h0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        if (pend) check_wb();
        exec_instr_i      = instr;
        exec_control_i    = ctrl;
        exec_alu_result_i = addr;
        exec_data_i       = data;
        exec_rd_addr_i    = rd;
        exec_pcplus_i     = pc;
      end
      fin = 1'b0;
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = 32'h0BAD_0BAD;
      if (granted && !exp_we && !answered) begin
        if (rsp_wait == rv_dly) begin
          dmem_rvalid_i = 1'b1;
          dmem_rdata_i  = mem[req_addr[9:2]];
          answered      = 1'b1;
          fin           = 1'b1;
        end else begin
          rsp_wait++;
        end
      end
      if (dmem_req_o) begin
        if (!prev_req) req_cnt++;
        req_addr = dmem_addr_o;
        chk("dmem_addr", dmem_addr_o, {addr[31:2], 2'b00});
        chk("dmem_we", {31'h0, dmem_we_o}, {31'h0, exp_we});
        if (exp_we) begin
          chk("dmem_be", {28'h0, dmem_be_o}, {28'h0, exp_be});
          chk("dmem_wdata", dmem_wdata_o, exp_wd);
        end
        req_cycles++;
        if (req_cycles > gnt_dly) begin
          dmem_gnt_i = 1'b1;
          granted    = 1'b1;
          if (exp_we) begin
            for (int k = 0; k < 4; k++)
              if (dmem_be_o[k]) mem[dmem_addr_o[9:2]][8*k +: 8] = dmem_wdata_o[8*k +: 8];
            fin = 1'b1;
          end else if (rv_with_gnt) begin
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = 32'h1234_5678;
          end
        end
      end
      prev_req   = dmem_req_o;
      wb_ready_i = !(done_phase && stall_left > 0);
      #1;
      if (!wb_ready_i) begin
        stall_left--;
        chk("stall_exec_ready", {31'h0, exec_ready_o}, 32'h0);
        chk("stall_wb_instr", wb_instr_o, last.instr);
        chk("stall_wb_ld", wb_load_data_o, last.ld);
      end else if (exec_ready_o) begin
        lat = cyc;
        break;
      end
      if (fin) done_phase = 1'b1;
    end
    chk("retired_in_time", {31'h0, lat >= 0}, 32'h1);
    chk("latency", lat, exp_lat);
    chk("req_count", req_cnt, exp_req);
    pend = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst_i = 1'b1; wb_ready_i = 1'b1;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    drive_nop();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_wb_instr", wb_instr_o, `I_NOP);
    chk("rst_wb_ctrl", {{(32-`CONTROL_BIT){1'b0}}, wb_control_o}, 32'h0);
    chk("rst_wb_alu", wb_alu_result_o, 32'h0);
    chk("rst_wb_ld", wb_load_data_o, 32'h0);
    chk("rst_wb_pc", wb_pcplus_o, 32'h0);
    chk("rst_req", {31'h0, dmem_req_o}, 32'h0);
    chk("rst_we", {31'h0, dmem_we_o}, 32'h0);
    chk("rst_be", {28'h0, dmem_be_o}, 32'h0);
    chk("rst_mis", {31'h0, wb_misalign_o}, 32'h0);
    chk("rst_exec_ready", {31'h0, exec_ready_o}, 32'h1);
    last = '{`I_NOP, `CONTROL_NOP, 32'h0, 5'h0, 32'h0, 32'h0, 1'b0};
    rst_i = 1'b0;

    // instr, rd, addr, data, exp_ld, mis, req, we, be, wdata, gnt, rv, rv+gnt, stall, lat
    run_op(mk(OPC_ALUI, 3'b000, 5'd1), 5'd1, 32'h0000_0005, 32'h0, 32'h0, 1'b0, 0, 1'b0, 4'h0, 32'h0, 0, 0, 1'b0, 0, 0);
    run_op(mk(OPC_LOAD, 3'b011, 5'd2), 5'd2, 32'h0000_0100, 32'h0, 32'h0, 1'b0, 0, 1'b0, 4'h0, 32'h0, 0, 0, 1'b0, 0, 0);
    run_op(mk(OPC_STORE,3'b010, 5'd0), 5'd0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0, 1, 1'b1, 4'b1111, 32'hDEAD_BEEF, 0, 0, 1'b0, 0, 2);
    run_op(mk(OPC_LOAD, 3'b010, 5'd3), 5'd3, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 1, 1'b0, 4'h0, 32'h0, 0, 0, 1'b0, 0, 3);
    run_op(mk(OPC_STORE,3'b000, 5'd0), 5'd0, 32'h0000_0103, 32'hFFFF_FF80, 32'h0, 1'b0, 1, 1'b1, 4'b1000, 32'h8080_8080, 0, 0, 1'b0, 0, 2);
    run_op(mk(OPC_LOAD, 3'b000, 5'd4), 5'd4, 32'h0000_0103, 32'h0, 32'hFFFF_FF80, 1'b0, 1, 1'b0, 4'h0, 32'h0, 0, 0, 1'b0, 0, 3);
    run_op(mk(OPC_LOAD, 3'b100, 5'd5), 5'd5, 32'h0000_0103, 32'h0, 32'h0000_0080, 1'b0, 1, 1'b0, 4'h0, 32'h0, 0, 0, 1'b0, 0, 3);
    run_op(mk(OPC_STORE,3'b001, 5'd0), 5'd0, 32'h0000_0102, 32'hABCD_1234, 32'h0, 1'b0, 1, 1'b1, 4'b1100, 32'h1234_1234, 0, 0, 1'b0, 0, 2);
    run_op(mk(OPC_LOAD, 3'b001, 5'd6), 5'd6, 32'h0000_0102, 32'h0, 32'h0000_1234, 1'b0, 1, 1'b0, 4'h0, 32'h0, 0, 0, 1'b0, 0, 3);
    run_op(mk(OPC_LOAD, 3'b101, 5'd7), 5'd7, 32'h0000_0100, 32'h0, 32'h0000_BEEF, 1'b0, 1, 1'b0, 4'h0, 32'h0, 0, 0, 1'b0, 0, 3);
    run_op(mk(OPC_LOAD, 3'b001, 5'd8), 5'd8, 32'h0000_0100, 32'h0, 32'hFFFF_BEEF, 1'b0, 1, 1'b0, 4'h0, 32'h0, 0, 0, 1'b0, 0, 3);
    // gnt after 3 extra cycles, rvalid 2 cycles late
    run_op(mk(OPC_LOAD, 3'b010, 5'd9), 5'd9, 32'h0000_0100, 32'h0, 32'h1234_BEEF, 1'b0, 1, 1'b0, 4'h0, 32'h0, 3, 2, 1'b0, 0, 8);
    // writeback holds off for 4 cycles in DONE
    run_op(mk(OPC_LOAD, 3'b000, 5'd10), 5'd10, 32'h0000_0100, 32'h0, 32'hFFFF_FFEF, 1'b0, 1, 1'b0, 4'h0, 32'h0, 0, 0, 1'b0, 4, 7);
    // junk rvalid together with gnt must be ignored
    run_op(mk(OPC_LOAD, 3'b010, 5'd11), 5'd11, 32'h0000_0100, 32'h0, 32'h1234_BEEF, 1'b0, 1, 1'b0, 4'h0, 32'h0, 0, 0, 1'b1, 0, 3);
`ifdef MEM_MISALIGN_TRAP_EN
    run_op(mk(OPC_LOAD, 3'b001, 5'd12), 5'd12, 32'h0000_0101, 32'h0, 32'h0, 1'b1, 0, 1'b0, 4'h0, 32'h0, 0, 0, 1'b0, 0, 1);
`else
    run_op(mk(OPC_LOAD, 3'b001, 5'd12), 5'd12, 32'h0000_0101, 32'h0, 32'hFFFF_BEEF, 1'b0, 1, 1'b0, 4'h0, 32'h0, 0, 0, 1'b0, 0, 3);
`endif
    run_op(mk(OPC_STORE,3'b000, 5'd0), 5'd0, 32'h0000_0101, 32'h0000_005A, 32'h0, 1'b0, 1, 1'b1, 4'b0010, 32'h5A5A_5A5A, 0, 0, 1'b0, 0, 2);
    run_op(mk(OPC_LOAD, 3'b100, 5'd13), 5'd13, 32'h0000_0101, 32'h0, 32'h0000_005A, 1'b0, 1, 1'b0, 4'h0, 32'h0, 0, 0, 1'b0, 0, 3);

    // Reset while waiting in RSP; the late rvalid must not be captured
    @(negedge clk);
    if (pend) check_wb();
    wb_ready_i = 1'b1;
    exec_instr_i = mk(OPC_LOAD, 3'b010, 5'd14); exec_control_i = `CONTROL_NOP;
    exec_alu_result_i = 32'h0000_0100; exec_data_i = 32'h0; exec_rd_addr_i = 5'd14; exec_pcplus_i = 32'h2000;
    for (int i = 0; i < 6 && !dmem_req_o; i++) @(negedge clk);
    chk("rst_seq_req_seen", {31'h0, dmem_req_o}, 32'h1);
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    rst_i = 1'b1;
    drive_nop();
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("rst_rsp_req", {31'h0, dmem_req_o}, 32'h0);
    chk("rst_rsp_wb_instr", wb_instr_o, `I_NOP);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hCAFE_F00D;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    #1;
    chk("late_rvalid_ld", wb_load_data_o, 32'h0);
    chk("late_rvalid_instr", wb_instr_o, `I_NOP);
    chk("late_rvalid_req", {31'h0, dmem_req_o}, 32'h0);
    chk("late_rvalid_ready", {31'h0, exec_ready_o}, 32'h1);

    run_op(mk(OPC_ALUI, 3'b111, 5'd15), 5'd15, 32'h0000_0F0F, 32'h0, 32'h0, 1'b0, 0, 1'b0, 4'h0, 32'h0, 0, 0, 1'b0, 0, 0);
    @(negedge clk);
    if (pend) check_wb();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
